// File: rtl/dram_arbiter_if.sv
// Request/response bundle between the upstream DRAM masters, the arbiter and dram_buf.
// The arbiter connects through the master modport; the environment uses slave.
interface dram_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 128
);
  logic [N_PORTS-1:0]             up_valid;
  logic [N_PORTS-1:0]             up_ready;
  logic [N_PORTS-1:0]             up_we;
  logic [N_PORTS-1:0][ADDR_W-1:0] up_addr;
  logic [N_PORTS-1:0][DATA_W-1:0] up_wdata;
  logic [N_PORTS-1:0]             up_rsp_valid;
  logic [DATA_W-1:0]              up_rsp_data;
  logic                           dn_valid;
  logic                           dn_ready;
  logic                           dn_we;
  logic [ADDR_W-1:0]              dn_addr;
  logic [DATA_W-1:0]              dn_wdata;
  logic                           dn_rsp_valid;
  logic [DATA_W-1:0]              dn_rsp_data;
  logic                           rsp_err;

  modport master (
    input  up_valid, up_we, up_addr, up_wdata, dn_ready, dn_rsp_valid, dn_rsp_data,
    output up_ready, up_rsp_valid, up_rsp_data, dn_valid, dn_we, dn_addr, dn_wdata, rsp_err
  );

  modport slave (
    output up_valid, up_we, up_addr, up_wdata, dn_ready, dn_rsp_valid, dn_rsp_data,
    input  up_ready, up_rsp_valid, up_rsp_data, dn_valid, dn_we, dn_addr, dn_wdata, rsp_err
  );
endinterface

// File: rtl/dram_arbiter.sv
// N-port round-robin DRAM front-end with an in-order port-tag FIFO for read responses.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module dram_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  dram_arbiter_if.master bus
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int CW = TW + 2;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                       state;
  logic [PW-1:0]                rr_ptr, win, win_q;
  logic [TAG_DEPTH-1:0][PW-1:0] tag_mem;
  logic [TW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                tag_cnt, reads_inflight;
  logic [N_PORTS-1:0]           elig, rsp_vld;
  logic                         any_elig, push, pop;
  logic                         dn_vld, dn_we;
  logic [ADDR_W-1:0]            dn_addr;
  logic [DATA_W-1:0]            dn_wdata, rsp_data;
  logic                         rsp_err;

  // Counting the read sitting in ISSUE keeps the tag FIFO from overflowing.
  always_comb begin
    reads_inflight = tag_cnt + CW'(state == ISSUE && !dn_we);
    for (int i = 0; i < N_PORTS; i++)
      elig[i] = bus.up_valid[i] && (bus.up_we[i] || reads_inflight < CW'(TAG_DEPTH));
    any_elig = |elig;
  end

  // Scan from the far end so the last hit is the highest-priority eligible port.
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (elig[i]) win = PW'(i);
  end
`else
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (elig[idx]) win = PW'(idx);
    end
  end
`endif

  assign bus.up_ready = (state == IDLE && any_elig) ? (N_PORTS'(1) << win) : '0;
  assign push         = dn_vld && bus.dn_ready && !dn_we;
  assign pop          = bus.dn_rsp_valid && (tag_cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win_q    <= '0;
      dn_vld   <= 1'b0;
      dn_we    <= 1'b0;
      dn_addr  <= '0;
      dn_wdata <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
      rsp_vld  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_elig) begin
          win_q    <= win;
          dn_vld   <= 1'b1;
          dn_we    <= bus.up_we[win];
          dn_addr  <= bus.up_addr[win];
          dn_wdata <= bus.up_wdata[win];
          state    <= ISSUE;
        end
        ISSUE: if (bus.dn_ready) begin
          dn_vld <= 1'b0;
          state  <= IDLE;
`ifdef ARB_FIXED_PRIO_EN
          rr_ptr <= '0;
`else
          rr_ptr <= (win_q == PW'(N_PORTS - 1)) ? '0 : win_q + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase

      rsp_vld <= pop ? (N_PORTS'(1) << tag_mem[rd_ptr]) : '0;
      if (pop) rsp_data <= bus.dn_rsp_data;
      if (bus.dn_rsp_valid && !pop) rsp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) tag_mem[wr_ptr] <= win_q;

  assign bus.dn_valid     = dn_vld;
  assign bus.dn_we        = dn_we;
  assign bus.dn_addr      = dn_addr;
  assign bus.dn_wdata     = dn_wdata;
  assign bus.up_rsp_valid = rsp_vld;
  assign bus.up_rsp_data  = rsp_data;
  assign bus.rsp_err      = rsp_err;
endmodule
